// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port memory with a watchdog abort.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_BUSY,
    DATA_BUSY
  } state_e;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  d_done_q, d_done_d;
  logic [15:0]           wdog_q, wdog_d;
  logic                  err_q, err_d;
  logic                  pick_data;
  logic                  wd_hit;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q: 1 = data owned the previous access
  logic last_q, last_d;

  assign pick_data = d_req & (~if_req | ~last_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= 1'b0;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if ((state_q != IDLE) && (mem_ready || wd_hit))
      last_d = (state_q == DATA_BUSY);
  end
`else
  assign pick_data = d_req;
`endif

  assign wd_hit = (wdog_q == WD_LIMIT);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    wdog_d     = wdog_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (pick_data) begin
          state_d = DATA_BUSY;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (if_req) begin
          state_d = FETCH_BUSY;
          we_d    = 1'b0;
          addr_d  = if_addr;
        end
      end
      FETCH_BUSY, DATA_BUSY: begin
        priority case (1'b1)
          mem_ready: begin
            state_d = IDLE;
            we_d    = 1'b0;
            wdog_d  = '0;
            if (state_q == FETCH_BUSY) begin
              if_rdata_d = mem_rdata;
              if_done_d  = 1'b1;
            end else begin
              if (!we_q) d_rdata_d = mem_rdata;
              d_done_d = 1'b1;
            end
          end
          wd_hit: begin
            state_d = IDLE;
            we_d    = 1'b0;
            wdog_d  = '0;
            err_d   = 1'b1;
            if (state_q == FETCH_BUSY) begin
              if_rdata_d = '0;
              if_done_d  = 1'b1;
            end else begin
              d_rdata_d = '0;
              d_done_d  = 1'b1;
            end
          end
          default: wdog_d = wdog_q + 16'd1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
    end
  end

  assign mem_req     = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_done     = if_done_q;
  assign d_done      = d_done_q;
  assign timeout_err = err_q;

endmodule
